// File: rtl/imo_req_bridge.sv
// Bridges queued 128-bit IMO instructions to the memory-controller request port and
// drains each 512-bit response as eight 64-bit beats. Optional macro: IMO_TIMEOUT_EN.
module imo_req_bridge #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_calib_complete,
    input  logic         cpu_inst_valid,
    output logic         cpu_inst_ready,
    input  logic [127:0] cpu_inst,
    output logic         imo_req_valid,
    input  logic         imo_req_ack,
    output logic [127:0] imo_req_inst,
    input  logic         imo_resp_valid,
    input  logic [511:0] imo_resp_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [63:0]  rsp_data,
    output logic         rsp_last,
    output logic         rsp_err,
    output logic         busy,
    output logic         spurious_resp
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StReq, StWaitResp, StDrain} state_e;

    state_e             state_q;
    logic [127:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [511:0]       resp_buf_q;
    logic [2:0]         beat_q;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               timeout;
    logic               start_drain;
    logic [511:0]       cap_data;

    assign full           = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty          = (count_q == '0);
    assign cpu_inst_ready = !full;
    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign push           = cpu_inst_valid && !full;
    assign pop            = (state_q == StReq) && imo_req_ack;
    assign busy           = (state_q != StIdle) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cpu_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef IMO_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_q;
    logic             err_q;

    assign timeout = (state_q == StWaitResp) && !imo_resp_valid &&
                     (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err = err_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != StWaitResp) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (state_q == StDrain && rsp_ready && beat_q == 3'd7) begin
            err_q <= 1'b0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign rsp_err            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // A timed-out response drains as zeroes.
    assign cap_data    = timeout ? '0 : imo_resp_data;
    assign start_drain = ((state_q == StWaitResp) && (imo_resp_valid || timeout)) ||
                         (pop && imo_req_inst[127] && imo_resp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            imo_req_valid <= 1'b0;
            imo_req_inst  <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_last      <= 1'b0;
            beat_q        <= '0;
            resp_buf_q    <= '0;
            spurious_resp <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (imo_resp_valid) spurious_resp <= 1'b1;
                    if (!empty && init_calib_complete) begin
                        state_q       <= StReq;
                        imo_req_valid <= 1'b1;
                        imo_req_inst  <= fifo_mem[rd_ptr_q];
                    end
                end
                StReq: begin
                    if (imo_req_ack) begin
                        imo_req_valid <= 1'b0;
                        imo_req_inst  <= '0;
                        state_q       <= imo_req_inst[127] ? StWaitResp : StIdle;
                        if (imo_resp_valid && !imo_req_inst[127]) spurious_resp <= 1'b1;
                    end else if (imo_resp_valid) begin
                        spurious_resp <= 1'b1;
                    end
                end
                StWaitResp: begin
                end
                StDrain: begin
                    if (imo_resp_valid) spurious_resp <= 1'b1;
                    if (rsp_ready) begin
                        if (beat_q == 3'd7) begin
                            state_q   <= StIdle;
                            rsp_valid <= 1'b0;
                            rsp_data  <= '0;
                            rsp_last  <= 1'b0;
                            beat_q    <= '0;
                        end else begin
                            beat_q   <= beat_q + 3'd1;
                            rsp_data <= resp_buf_q[{beat_q + 3'd1, 6'd0} +: 64];
                            rsp_last <= (beat_q == 3'd6);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (start_drain) begin
                state_q    <= StDrain;
                resp_buf_q <= cap_data;
                rsp_valid  <= 1'b1;
                rsp_data   <= cap_data[63:0];
                rsp_last   <= 1'b0;
                beat_q     <= '0;
            end
        end
    end

endmodule

// File: doc/imo_req_bridge.md
IMO_REQ_BRIDGE -- requirements
Module: imo_req_bridge

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FIFO_DEPTH, 4, instruction FIFO entries, power of two, 2..16
- TIMEOUT_CYCLES, 4096, response-wait limit in clk cycles
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock (memory-controller UI clock)
- rst, in, 1, synchronous, active-high reset
- init_calib_complete, in, 1, PHY calibration done
- cpu_inst_valid, in, 1, upstream instruction offered
- cpu_inst_ready, out, 1, FIFO can accept
- cpu_inst, in, 128, IMO instruction; bit 127 = RESP_EXP
- imo_req_valid, out, 1, request to memory controller
- imo_req_ack, in, 1, one-cycle acceptance pulse from memory controller
- imo_req_inst, out, 128, instruction at FIFO head
- imo_resp_valid, in, 1, one-cycle response pulse
- imo_resp_data, in, 512, response payload
- rsp_valid, out, 1, response beat available
- rsp_ready, in, 1, downstream accepts beat
- rsp_data, out, 64, response beat
- rsp_last, out, 1, final beat of a response
- rsp_err, out, 1, beat belongs to a timed-out response
- busy, out, 1, FSM not IDLE or FIFO not empty
- spurious_resp, out, 1, sticky: response seen outside WAIT_RESP

Function
REQ-003 FIFO write on cpu_inst_valid && cpu_inst_ready; cpu_inst_ready = !full.
REQ-004 Full FIFO: cpu_inst_ready low, no write; a push and a pop in the same cycle on a full FIFO pops only and leaves ready low that cycle.
REQ-005 Pointers wrap modulo FIFO_DEPTH; occupancy is held in a counter of width log2(FIFO_DEPTH)+1.
REQ-006 FSM states: IDLE, REQ, WAIT_RESP, DRAIN.
REQ-007 IDLE->REQ when FIFO not empty and init_calib_complete; otherwise remain in IDLE.
REQ-008 In REQ: imo_req_valid=1 and imo_req_inst=FIFO head, held stable until imo_req_ack.
REQ-009 On imo_req_ack in REQ: pop FIFO; go to WAIT_RESP if RESP_EXP=1, else IDLE.
REQ-010 imo_req_ack outside REQ is ignored.
REQ-011 Only one request is outstanding at a time.
REQ-012 In WAIT_RESP, imo_resp_valid captures imo_resp_data into a 512-bit buffer and moves to DRAIN.
REQ-013 imo_resp_valid in the same cycle as the ack of a RESP_EXP=1 request is captured; FSM goes directly to DRAIN.
REQ-014 In DRAIN, beat k (0..7) = buffer[64k+63:64k]; rsp_valid=1; beat advances on rsp_valid && rsp_ready.
REQ-015 rsp_last=1 on beat 7; after the beat-7 handshake the FSM returns to IDLE.
REQ-016 Beat data and rsp_last are held stable while rsp_ready=0.
REQ-017 imo_resp_valid in IDLE, REQ or DRAIN: sets spurious_resp and is otherwise ignored, with no buffer change.
REQ-018 Latency: IDLE->imo_req_valid is 1 cycle after FIFO becomes non-empty; first rsp beat is valid the cycle after imo_resp_valid.
REQ-019 rsp_err=0 except as defined under Configuration.

Reset
REQ-020 rst sampled on posedge clk sets: FSM=IDLE; FIFO empty; beat count 0; all outputs 0 except cpu_inst_ready=1.
REQ-021 Reset mid-operation (any state) discards the FIFO contents, the outstanding request and the buffered response; later responses for the discarded request count as spurious.

Configuration
REQ-022 Macro IMO_TIMEOUT_EN defined:
- Counter runs in WAIT_RESP.
- At TIMEOUT_CYCLES with no response: buffer is zeroed, FSM enters DRAIN, and all 8 beats carry rsp_err=1.
REQ-023 IMO_TIMEOUT_EN undefined: no counter; WAIT_RESP waits indefinitely; rsp_err is tied to 0.

Verification
REQ-024 Push inst RESP_EXP=0 with calibration done; ack after 3 cycles -> imo_req_valid high 3 cycles then low, FSM returns to IDLE, no rsp_valid.
REQ-025 RESP_EXP=1, ack, then resp data = 512'h{beats 0..7 = 64'h0..64'h7} -> eight beats 0..7, rsp_last only on beat 7; rsp_ready toggling 1/0 keeps data stable.
REQ-026 Push 5 insts with FIFO_DEPTH=4 and no ack -> 5th held with cpu_inst_ready=0; after acks, issue order is 1..5.
REQ-027 Ack and resp in the same cycle; separately, resp while in IDLE -> first goes to DRAIN; second sets spurious_resp=1, no rsp_valid.
REQ-028 With IMO_TIMEOUT_EN and TIMEOUT_CYCLES=16, no response -> 8 zero beats with rsp_err=1.
REQ-029 Assert rst during DRAIN beat 3 -> next cycle rsp_valid=0, busy=0, cpu_inst_ready=1.
